fakeram_32x46_initiator: RTL
============================

# fakeram_32x46_initiator

Request-side initiator for the 32-word x 46-bit single-port fake RAM macro. It accepts read/write requests on a valid/ready channel and drives the macro's `ce_in`/`we_in`/`addr_in`/`wd_in` pins. It captures `rd_out` one cycle after each read and returns the data on a valid/ready response channel through a 2-entry buffer. It sits between a client (core or test engine) and the macro, and keeps the macro's address and write-enable pins X-free whenever no request is issued.

## Interface
Parameters:
- BITS, 46, data width
- WORD_DEPTH, 32, number of words in the macro
- ADDR_WIDTH, 5, address width
- CNT_WIDTH, 16, width of the access counters

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready (a "fire")
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  BITS  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  client takes the response
- rsp_rdata  out  BITS  read data, valid while rsp_valid is high
- ce_in  out  1  macro chip enable
- we_in  out  1  macro write enable
- addr_in  out  ADDR_WIDTH  macro address
- wd_in  out  BITS  macro write data
- rd_out  in  BITS  macro read data
- rd_count  out  CNT_WIDTH  accepted reads, saturating
- wr_count  out  CNT_WIDTH  accepted writes, saturating

## Operation
- Reset (async, rst_n=0) clears:
  - rd_inflight = 0
  - FIFO count = 0, read and write pointers = 0
  - rd_count = 0, wr_count = 0
- During reset:
  - rsp_valid = 0 and req_ready = 0 (forced combinationally by rst_n low)
  - ce_in, we_in, addr_in and wd_in are all 0
- occ = rd_inflight + fifo_cnt. pop = rsp_valid && rsp_ready.
- req_ready = rst_n && (occ - pop < 2). This applies to writes as well as reads. The path from rsp_ready to req_ready is combinational by design.
- Macro pins, combinational from the fire condition:
  - ce_in = fire
  - we_in = fire && req_we
  - addr_in = fire ? req_addr : 0
  - wd_in = (fire && req_we) ? req_wdata : 0
- Pins are never X while rst_n is high, provided req_valid is known. Any X on req_addr or req_we during a fire is a client error.
- Read fire: rd_inflight is set to 1 at the next edge. Otherwise it is cleared at the next edge.
- When rd_inflight = 1, rd_out is pushed into the response FIFO at the end of that cycle.
- Write fire: no response is produced. wr_count increments.
- Read fire: rd_count increments.
- Both counters saturate at 2^CNT_WIDTH-1 and do not wrap.
- Response FIFO:
  - Depth 2; pointers are 1 bit wide and wrap.
  - rsp_rdata = mem[rd_ptr].
  - rsp_valid = fifo_cnt != 0.
  - A push and a pop in the same cycle leave the count unchanged.
  - The credit rule guarantees no push when full; the bench asserts this.
- Responses are returned in request order. Write-then-read to the same address in consecutive cycles is ordered by the macro itself.

## Timing
- Read fire in cycle N:
  - Macro samples the pins at the edge ending N.
  - rd_out is valid in N+1 and is pushed at the edge ending N+1.
  - rsp_valid is high in N+2.
  - Latency is 2 cycles.
- Write fire in cycle N: the macro updates at the edge ending N.
- Throughput:
  - Back-to-back reads run at 1 per cycle while rsp_ready = 1.
  - With rsp_ready = 0, at most 2 reads are outstanding. req_ready drops once occ = 2 and rises in the same cycle rsp_ready rises.
- rsp_valid and rsp_rdata are held stable while rsp_ready = 0.
- Reset asserted mid-operation discards the in-flight read and all buffered data. The first cycle after release has req_ready = 1 and rsp_valid = 0.

## Test plan
- Reset check: hold rst_n=0 with req_valid=1 -> req_ready=0, ce_in=0, addr_in=0, rsp_valid=0, counters 0.
- Write then read: write 46'h155 to addr 3, then read addr 3 (rsp_ready=1).
  - Read fire in cycle N -> rsp_valid at N+2, rsp_rdata=46'h155.
  - wr_count=1, rd_count=1.
- Streaming reads: 8 back-to-back reads of addr 0..7 with rsp_ready=1 -> req_ready stays 1, responses arrive in order on 8 consecutive cycles.
- Backpressure: rsp_ready=0 while issuing 4 reads.
  - Only 2 fire; req_ready=0 from the third.
  - Raising rsp_ready makes req_ready=1 in the same cycle; all 4 responses arrive in order, with no loss or duplication.
- Idle cleanliness: req_valid=0 for 10 cycles -> ce_in=0, we_in=0, addr_in=0, wd_in=0 every cycle.
- Reset mid-flight: read fires, rst_n pulses low in the next cycle -> rsp_valid never rises for that read, and rd_count is 0 after the reset.

Source files
------------

// File: rtl/fakeram_32x46_initiator.sv
// Request-side initiator for the 32x46 fake RAM macro: drives macro pins on a request
// fire, captures rd_out one cycle later and returns it through a 2-entry response FIFO.
module fakeram_32x46_initiator #(
    parameter int BITS       = 46,
    parameter int WORD_DEPTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  ce_in,
    output logic                  we_in,
    output logic [ADDR_WIDTH-1:0] addr_in,
    output logic [BITS-1:0]       wd_in,
    input  logic [BITS-1:0]       rd_out,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    if (WORD_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("WORD_DEPTH does not fit in ADDR_WIDTH");
    end

    logic                 rd_inflight_q, rd_inflight_d;
    logic [1:0]           fifo_cnt_q, fifo_cnt_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0][BITS-1:0] mem_q, mem_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [CNT_WIDTH-1:0] wr_count_q, wr_count_d;

    logic [2:0] occ;
    logic       pop, push, fire;

    always_comb begin
        occ       = {2'b00, rd_inflight_q} + {1'b0, fifo_cnt_q};
        rsp_valid = rst_n && (fifo_cnt_q != 2'd0);
        pop       = rsp_valid && rsp_ready;
        // Credit counts the read in flight, so a fire can never overflow the FIFO.
        req_ready = rst_n && ((occ - {2'b00, pop}) < 3'd2);
        fire      = req_valid && req_ready;
        push      = rd_inflight_q;

        ce_in     = fire;
        we_in     = fire && req_we;
        addr_in   = fire ? req_addr : '0;
        wd_in     = (fire && req_we) ? req_wdata : '0;
        rsp_rdata = mem_q[rd_ptr_q];
        rd_count  = rd_count_q;
        wr_count  = wr_count_q;
    end

    always_comb begin
        rd_inflight_d = fire && !req_we;
        mem_d         = mem_q;
        if (push) mem_d[wr_ptr_q] = rd_out;
        wr_ptr_d      = wr_ptr_q ^ push;
        rd_ptr_d      = rd_ptr_q ^ pop;

        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (fire && !req_we && rd_count_q != CNT_MAX) rd_count_d = rd_count_q + 1'b1;
        if (fire &&  req_we && wr_count_q != CNT_MAX) wr_count_d = wr_count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_inflight_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            mem_q         <= '0;
            rd_count_q    <= '0;
            wr_count_q    <= '0;
        end else begin
            rd_inflight_q <= rd_inflight_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
        end
    end

endmodule
